// File: rtl/dcsk_frame_ctrl_if.sv
// Byte-source handshake into the DCSK frame sequencer: message byte, requested
// spreading factor and the valid/ready pair.
interface dcsk_frame_ctrl_if;
  logic [1:0] i_sf;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic       o_byte_ready;

  modport master (output i_sf, output i_byte, output i_byte_valid, input  o_byte_ready);
  modport slave  (input  i_sf, input  i_byte, input  i_byte_valid, output o_byte_ready);
endinterface

// File: rtl/dcsk_frame_ctrl.sv
// DCSK transmit frame sequencer: serialises accepted bytes MSB first, one bit per
// frame, each frame being a reference half followed by a modulated half.
module dcsk_frame_ctrl (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  dcsk_frame_ctrl_if.slave         byte_bus,
  output logic [1:0]               o_sf,
  output logic                     o_msg_bit,
  output logic                     o_frame_half,
  output logic                     o_chip_valid,
  output logic                     o_frame_start,
  output logic                     o_byte_done
);

  localparam logic [1:0] SF4  = 2'b00;
  localparam logic [1:0] SF8  = 2'b01;
  localparam logic [1:0] SF16 = 2'b10;
  localparam logic [1:0] SF32 = 2'b11;

  typedef enum logic [1:0] {IDLE, REF, DATA} state_t;

  state_t     state;
  logic [3:0] chip_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic [1:0] sf_q;
  logic [3:0] h_last;
  logic       last_chip;
  logic       byte_end;
  logic       accept;

  // Last chip index of a half, H-1, for the latched spreading factor.
  always_comb begin
    h_last = 4'd1;
    case (sf_q)
      SF4:     h_last = 4'd1;
      SF8:     h_last = 4'd3;
      SF16:    h_last = 4'd7;
      SF32:    h_last = 4'd15;
      default: h_last = 4'd1;
    endcase
  end

  assign last_chip = (chip_cnt == h_last);
  assign byte_end  = (state == DATA) && last_chip && (bit_cnt == 3'd7);

  // Ready depends only on registered state, never on i_byte_valid.
  assign byte_bus.o_byte_ready = (state == IDLE) || byte_end;
  assign accept                = byte_bus.i_byte_valid && byte_bus.o_byte_ready;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state    <= IDLE;
      chip_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      sf_q     <= SF4;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh       <= byte_bus.i_byte;
            sf_q     <= byte_bus.i_sf;
            bit_cnt  <= '0;
            chip_cnt <= '0;
            state    <= REF;
          end
        end
        REF: begin
          if (last_chip) begin
            chip_cnt <= '0;
            state    <= DATA;
          end else begin
            chip_cnt <= chip_cnt + 4'd1;
          end
        end
        DATA: begin
          if (!last_chip) begin
            chip_cnt <= chip_cnt + 4'd1;
          end else if (bit_cnt != 3'd7) begin
            chip_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            sh       <= {sh[6:0], 1'b0};
            state    <= REF;
          end else if (accept) begin
            // Back-to-back byte: reload on the last chip so no idle gap appears.
            sh       <= byte_bus.i_byte;
            sf_q     <= byte_bus.i_sf;
            bit_cnt  <= '0;
            chip_cnt <= '0;
            state    <= REF;
          end else begin
            chip_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_sf          = sf_q;
  assign o_msg_bit     = sh[7];
  assign o_frame_half  = (state == DATA);
  assign o_chip_valid  = (state != IDLE);
  assign o_frame_start = (state == REF) && (chip_cnt == 4'd0);
  assign o_byte_done   = byte_end;

endmodule

// File: tb/tb_dcsk_frame_ctrl.sv
// Bench for dcsk_frame_ctrl: a chip-position model of the frame timing checked
// every cycle, plus directed scenarios with literal expectations.
module tb_dcsk_frame_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dcsk_frame_ctrl_if bus ();

  logic [1:0] o_sf;
  logic       o_msg_bit, o_frame_half, o_chip_valid, o_frame_start, o_byte_done;

  dcsk_frame_ctrl dut (
    .i_clk         (clk),
    .i_arst_n      (rst_n),
    .byte_bus      (bus.slave),
    .o_sf          (o_sf),
    .o_msg_bit     (o_msg_bit),
    .o_frame_half  (o_frame_half),
    .o_chip_valid  (o_chip_valid),
    .o_frame_start (o_frame_start),
    .o_byte_done   (o_byte_done)
  );

  // Model: position p of the current chip within the byte (0 .. 16H-1).
  logic       m_active = 1'b0;
  logic [7:0] m_byte   = '0;
  logic [1:0] m_sf     = '0;
  int         m_h      = 2;
  int         m_p      = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_byte   = '0;
      m_sf     = '0;
      m_h      = 2;
      m_p      = 0;
    end else begin
      if (bus.i_byte_valid && (!m_active || m_p == 16 * m_h - 1)) begin
        m_active = 1'b1;
        m_byte   = bus.i_byte;
        m_sf     = bus.i_sf;
        m_h      = 2 << bus.i_sf;
        m_p      = 0;
      end else if (m_active) begin
        if (m_p == 16 * m_h - 1) m_active = 1'b0;
        else                     m_p      = m_p + 1;
      end
    end
  end

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  int         cnt_valid = 0, cnt_ones = 0, cnt_done = 0, cnt_fs = 0;
  int         cnt_vfall = 0, cnt_ready_busy = 0;
  logic [7:0] msg_cap   = '0;
  logic [1:0] done_sf   = '0;
  logic       prev_valid = 1'b0;
  logic       last_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_model();
    int  fl;
    int  pos;
    logic e_half, e_fs, e_done, e_ready, e_msg;
    fl      = 2 * m_h;
    pos     = m_p % fl;
    e_half  = m_active && (pos >= m_h);
    e_fs    = m_active && (pos == 0);
    e_done  = m_active && (m_p == 16 * m_h - 1);
    e_ready = !m_active || (m_p == 16 * m_h - 1);
    e_msg   = m_byte[7 - m_p / fl];
    chk("chip_valid",  int'(o_chip_valid),     int'(m_active));
    chk("frame_half",  int'(o_frame_half),     int'(e_half));
    chk("frame_start", int'(o_frame_start),    int'(e_fs));
    chk("byte_done",   int'(o_byte_done),      int'(e_done));
    chk("byte_ready",  int'(bus.o_byte_ready), int'(e_ready));
    chk("msg_bit",     int'(o_msg_bit),        int'(e_msg));
    chk("sf",          int'(o_sf),             int'(m_sf));
  endtask

  // One clock: compare and tally at the falling edge, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    compare_model();
    cnt_valid      += int'(o_chip_valid);
    cnt_ones       += int'(o_chip_valid && o_msg_bit);
    cnt_done       += int'(o_byte_done);
    cnt_fs         += int'(o_frame_start);
    cnt_ready_busy += int'(o_chip_valid && bus.o_byte_ready);
    if (prev_valid && !o_chip_valid) cnt_vfall++;
    if (o_frame_start) msg_cap = {msg_cap[6:0], o_msg_bit};
    if (o_byte_done) done_sf = o_sf;
    prev_valid = o_chip_valid;
    last_ready = bus.o_byte_ready;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      n++;
      if (last_ready) return;
    end
    chk("accept_timeout", 0, 1);
  endtask

  int s_valid, s_ones, s_done, s_fs, s_vfall, s_rb, n;

  task automatic snap();
    s_valid = cnt_valid; s_ones = cnt_ones; s_done = cnt_done;
    s_fs = cnt_fs; s_vfall = cnt_vfall; s_rb = cnt_ready_busy;
  endtask

  initial begin
    bus.i_sf         = 2'b00;
    bus.i_byte       = 8'h00;
    bus.i_byte_valid = 1'b0;

    // Reset then idle
    repeat (3) step();
    chk("rst_chip_valid", int'(o_chip_valid), 0);
    chk("rst_ready",      int'(bus.o_byte_ready), 1);
    chk("rst_sf",         int'(o_sf), 0);
    chk("rst_msg",        int'(o_msg_bit), 0);
    rst_n = 1'b1;
    snap();
    repeat (20) step();
    chk("idle_no_valid", cnt_valid - s_valid, 0);

    // SF4, 0xA5
    snap();
    bus.i_byte = 8'hA5; bus.i_sf = 2'b00; bus.i_byte_valid = 1'b1;
    step();
    bus.i_byte_valid = 1'b0;
    repeat (40) step();
    chk("a5_valid_cycles", cnt_valid - s_valid, 32);
    chk("a5_done",         cnt_done - s_done, 1);
    chk("a5_frame_starts", cnt_fs - s_fs, 8);
    chk("a5_msg_bits",     int'(msg_cap), 8'hA5);
    chk("a5_vfall",        cnt_vfall - s_vfall, 1);

    // SF32, 0xFF then 0x00 back to back
    snap();
    bus.i_byte = 8'hFF; bus.i_sf = 2'b11; bus.i_byte_valid = 1'b1;
    step();
    bus.i_byte = 8'h00;
    wait_accept(n);
    bus.i_byte_valid = 1'b0;
    chk("ff_second_accept", n, 256);
    repeat (300) step();
    chk("sf32_valid_cycles", cnt_valid - s_valid, 512);
    chk("sf32_continuous",   cnt_vfall - s_vfall, 1);
    chk("sf32_ones",         cnt_ones - s_ones, 256);
    chk("sf32_done",         cnt_done - s_done, 2);

    // SF change while a byte is in flight
    snap();
    bus.i_byte = 8'h3C; bus.i_sf = 2'b01; bus.i_byte_valid = 1'b1;
    step();
    bus.i_byte_valid = 1'b0;
    repeat (9) step();
    bus.i_sf = 2'b10;
    repeat (70) step();
    chk("sf8_byte_len", cnt_valid - s_valid, 64);
    chk("sf8_done_sf",  int'(done_sf), 1);
    snap();
    bus.i_byte = 8'h81; bus.i_byte_valid = 1'b1;
    step();
    bus.i_byte_valid = 1'b0;
    repeat (140) step();
    chk("sf16_byte_len", cnt_valid - s_valid, 128);
    chk("sf16_done_sf",  int'(done_sf), 2);
    chk("sf16_msg_bits", int'(msg_cap), 8'h81);

    // Reset in the SF8 DATA half
    snap();
    bus.i_byte = 8'hF0; bus.i_sf = 2'b01; bus.i_byte_valid = 1'b1;
    step();
    bus.i_byte_valid = 1'b0;
    repeat (6) step();
    chk("pre_rst_half", int'(o_frame_half), 1);
    chk("pre_rst_msg",  int'(o_msg_bit), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_chip_valid", int'(o_chip_valid), 0);
    chk("mid_rst_half",       int'(o_frame_half), 0);
    chk("mid_rst_msg",        int'(o_msg_bit), 0);
    chk("mid_rst_sf",         int'(o_sf), 0);
    chk("mid_rst_ready",      int'(bus.o_byte_ready), 1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("mid_rst_no_done", cnt_done - s_done, 0);
    snap();
    bus.i_byte = 8'h80; bus.i_sf = 2'b00; bus.i_byte_valid = 1'b1;
    step();
    bus.i_byte_valid = 1'b0;
    repeat (40) step();
    chk("post_rst_len",  cnt_valid - s_valid, 32);
    chk("post_rst_msg",  int'(msg_cap), 8'h80);
    chk("post_rst_done", cnt_done - s_done, 1);

    // Backpressure: second byte offered at T+3
    snap();
    bus.i_byte = 8'h5A; bus.i_sf = 2'b00; bus.i_byte_valid = 1'b1;
    step();
    bus.i_byte_valid = 1'b0;
    repeat (2) step();
    bus.i_byte = 8'h99; bus.i_byte_valid = 1'b1;
    wait_accept(n);
    bus.i_byte_valid = 1'b0;
    chk("bp_wait", n, 30);
    repeat (40) step();
    chk("bp_valid_cycles", cnt_valid - s_valid, 64);
    chk("bp_continuous",   cnt_vfall - s_vfall, 1);
    chk("bp_ready_busy",   cnt_ready_busy - s_rb, 2);
    chk("bp_msg_bits",     int'(msg_cap), 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
